// File: rtl/alu_sched_ctrl.sv
// Round-robin sequencer in front of a 4-bit registered ALU.
// Runs narrow ops in one ALU pass and 8-bit ADD/SUB as two chained nibble passes.
module alu_sched_ctrl #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [1:0] req0_mode,
  input  logic [1:0] req1_mode,
  input  logic [3:0] req0_sel,
  input  logic [3:0] req1_sel,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_cout,
  output logic       rsp_err,
  output logic       alu_en,
  output logic [3:0] alu_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_f,
  input  logic       alu_cout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC_LO = 3'd1,
    CAP_LO  = 3'd2,
    CAP_HI  = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [1:0] MODE_NARROW = 2'b00;
  localparam logic [1:0] MODE_ADD8   = 2'b01;
  localparam logic [1:0] MODE_SUB8   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // last_q holds the most recent grant, so reset loads the loser of RESET_PRIO
  localparam logic LAST_INIT = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       id_q, id_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] sel_q, sel_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_cout_q, rsp_cout_d;
  logic       rsp_err_q, rsp_err_d;

  logic       win_id;
  logic [1:0] win_mode;
  logic [3:0] win_sel;
  logic [7:0] win_a, win_b;

  always_comb begin
    if (req_valid == 2'b11) win_id = ~last_q;
    else                    win_id = req_valid[1];
  end

  assign win_mode = win_id ? req1_mode : req0_mode;
  assign win_sel  = win_id ? req1_sel  : req0_sel;
  assign win_a    = win_id ? req1_a    : req0_a;
  assign win_b    = win_id ? req1_b    : req0_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_INIT;
      id_q       <= 1'b0;
      mode_q     <= '0;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lo_q       <= '0;
      rsp_data_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lo_q       <= lo_d;
      rsp_data_q <= rsp_data_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    a_d        = a_q;
    b_d        = b_q;
    lo_d       = lo_q;
    rsp_data_d = rsp_data_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    alu_en     = 1'b0;
    alu_sel    = '0;
    alu_a      = '0;
    alu_b      = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[win_id] = 1'b1;
          last_d = win_id;
          id_d   = win_id;
          mode_d = win_mode;
          sel_d  = win_sel;
          a_d    = win_a;
          b_d    = win_b;
          if (win_mode == MODE_RSVD) begin
            rsp_data_d = '0;
            rsp_cout_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            rsp_err_d  = 1'b0;
            state_d    = EXEC_LO;
          end
        end
      end
      EXEC_LO: begin
        alu_en = 1'b1;
        alu_a  = a_q[3:0];
        alu_b  = b_q[3:0];
        unique case (mode_q)
          MODE_NARROW: alu_sel = sel_q;
          MODE_ADD8:   alu_sel = 4'b0010;
          default:     alu_sel = 4'b0101;
        endcase
        state_d = CAP_LO;
      end
      CAP_LO: begin
        if (mode_q == MODE_NARROW) begin
          rsp_data_d = {4'h0, alu_f};
          rsp_cout_d = alu_cout;
          state_d    = RESP;
        end else begin
          // High nibble issues in the capture cycle, chaining the low carry/borrow
          lo_d   = alu_f;
          alu_en = 1'b1;
          alu_a  = a_q[7:4];
          alu_b  = b_q[7:4];
          if (mode_q == MODE_SUB8) alu_sel = alu_cout ? 4'b0101 : 4'b0100;
          else                     alu_sel = alu_cout ? 4'b0011 : 4'b0010;
          state_d = CAP_HI;
        end
      end
      CAP_HI: begin
        rsp_data_d = {alu_f, lo_q};
        rsp_cout_d = alu_cout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;

endmodule
